// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the frame-buffer arbiter state type.
// vga_controller uses the same active-area and sync-polarity values.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;

    // Both syncs are active-low.
    localparam logic HS_ACTIVE = 1'b0;
    localparam logic VS_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        RUN        = 2'd1,
        DONE       = 2'd2
    } fb_state_t;

endpackage

// File: rtl/vga_pixel_fifo.sv
// Small synchronous pixel FIFO with level output and flush.
// Flush beats push; a push at full is accepted only alongside a pop.
module vga_pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 12,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             pixel_clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == LVL_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Storage carries no reset; the head read at full sees the old word
    // even when the same slot is written on this edge.
    always_ff @(posedge pixel_clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign level = level_reg;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port frame-buffer RAM between raster-order scanout prefetch
// and a host writer; the host is held off whenever the prefetch margin runs low.
module vga_fb_arbiter #(
    parameter int DATA_W     = 12,
    parameter int ADDR_W     = 19,
    parameter int H_ACTIVE   = vga_pkg::VGA_H_ACTIVE,
    parameter int V_ACTIVE   = vga_pkg::VGA_V_ACTIVE,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WM     = 4
) (
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic              VGA_VS,
    input  logic              data_en,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              underflow
);

    import vga_pkg::*;

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = LVL_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    fb_state_t         state_reg;
    fb_state_t         state_next;
    logic              vs_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              inflight_reg;
    logic [DATA_W-1:0] pix_data_reg;
    logic              underflow_reg;

    logic [DATA_W-1:0] fifo_head;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_empty;
    logic              fifo_push;
    logic              frame_start;
    logic [OCC_W-1:0]  occ;
    logic              urgent;
    logic              host_grant;
    logic              rd_grant;

    // Registered VS starts out "active" so only a genuinely observed falling
    // edge after reset can open a frame.
    assign frame_start = (vs_reg != VS_ACTIVE) && (VGA_VS == VS_ACTIVE);

    assign occ        = OCC_W'(fifo_level) + OCC_W'(inflight_reg);
    assign fifo_empty = (fifo_level == '0);
    assign urgent     = (state_reg == RUN) && (int'(occ) < LOW_WM);
    assign wr_ready   = rst && !urgent;
    assign host_grant = wr_valid && wr_ready;
    // No read in the frame-start cycle: it would fetch a stale address.
    assign rd_grant   = !host_grant && (state_reg == RUN) &&
                        (int'(occ) < FIFO_DEPTH) && !frame_start;
    assign fifo_push  = inflight_reg && !frame_start;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (host_grant) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end else if (rd_grant) begin
            mem_en    = 1'b1;
            mem_addr  = rd_addr_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (frame_start) begin
            state_next = RUN;
        end else if ((state_reg == RUN) && rd_grant && (rd_addr_reg == LAST_ADDR)) begin
            state_next = DONE;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= WAIT_FRAME;
            vs_reg       <= VS_ACTIVE;
            rd_addr_reg  <= '0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            vs_reg       <= VGA_VS;
            inflight_reg <= rd_grant;
            if (frame_start) begin
                rd_addr_reg <= '0;
            end else if (rd_grant) begin
                rd_addr_reg <= rd_addr_reg + 1'b1;
            end
        end
    end

    vga_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .flush     (frame_start),
        .push      (fifo_push),
        .push_data (mem_rdata),
        .pop       (data_en),
        .head      (fifo_head),
        .level     (fifo_level)
    );

    // Starvation only counts once a frame is under way; before the first VS
    // edge after reset the output is simply black.
    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            pix_data_reg  <= '0;
            underflow_reg <= 1'b0;
        end else begin
            pix_data_reg <= '0;
            if (data_en && !fifo_empty) begin
                pix_data_reg <= fifo_head;
            end
            if (frame_start) begin
                underflow_reg <= 1'b0;
            end else if (data_en && fifo_empty && (state_reg != WAIT_FRAME)) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign pix_data  = pix_data_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomised bench for vga_fb_arbiter on a small 8x4 frame: a shadow image of
// the RAM predicts every scanned pixel, a separate monitor pops and compares.
module tb_vga_fb_arbiter;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int NPIX = H * V;
    localparam int DW   = 12;
    localparam int AW   = 19;

    logic          pixel_clk = 1'b0;
    logic          rst       = 1'b0;
    logic          VGA_VS    = 1'b1;
    logic          data_en   = 1'b0;
    logic          wr_valid  = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr   = '0;
    logic [DW-1:0] wr_data   = '0;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pix_data;
    logic          underflow;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] ram       [64];
    logic [DW-1:0] model_ram [64];
    logic [DW-1:0] exp_q [$];
    int            rd_addr_q [$];
    int            rd_cyc_q [$];

    int   host_mode = 0;  // 0 idle, 1 image load, 2 saturating off-screen, 3 random anywhere
    int   load_ptr  = 0;
    logic mon_en    = 1'b0;
    logic de_prev   = 1'b0;

    vga_fb_arbiter #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FIFO_DEPTH (16),
        .LOW_WM     (4)
    ) dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .VGA_VS    (VGA_VS),
        .data_en   (data_en),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pix_data  (pix_data),
        .underflow (underflow)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Single-port RAM, read data one cycle after the strobe.
    always @(posedge pixel_clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[5:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 0);
        chk({tag, "_mem_en"}, 32'(mem_en), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_pix_data"}, 32'(pix_data), 0);
        chk({tag, "_underflow"}, 32'(underflow), 0);
    endtask

    // Host writer: records every accepted write into the shadow image.
    initial begin
        forever begin
            @(negedge pixel_clk);
            if (wr_valid && wr_ready) begin
                chk("wr_mem_en", 32'(mem_en), 1);
                chk("wr_mem_we", 32'(mem_we), 1);
                chk("wr_mem_addr", 32'(mem_addr), 32'(wr_addr));
                chk("wr_mem_wdata", 32'(mem_wdata), 32'(wr_data));
                model_ram[wr_addr[5:0]] = wr_data;
                if (host_mode == 1) load_ptr++;
            end else if (wr_valid) begin
                chk("wr_blocked_no_write", 32'(mem_we), 0);
            end
            @(posedge pixel_clk);
            #1;
            wr_data = DW'($urandom);
            case (host_mode)
                1: begin
                    wr_valid = (load_ptr < 64);
                    wr_addr  = AW'(load_ptr);
                end
                2: begin
                    wr_valid = 1'b1;
                    wr_addr  = AW'(NPIX + $urandom_range(0, 31));
                end
                3: begin
                    wr_valid = ($urandom_range(0, 3) != 0);
                    wr_addr  = AW'($urandom_range(0, 63));
                end
                default: wr_valid = 1'b0;
            endcase
        end
    end

    // Pixel monitor: every data_en cycle owes one expected pixel next cycle.
    always @(negedge pixel_clk) begin
        if (mon_en) begin
            if (de_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pix_unexpected actual=%0h expected=none", pix_data);
                end else begin
                    chk("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
                end
            end else begin
                chk("pix_blank_black", 32'(pix_data), 0);
            end
            chk("underflow_clear", 32'(underflow), 0);
        end
        de_prev = data_en;
    end

    task automatic vs_edge(input int pre_blank);
        @(posedge pixel_clk); #1 VGA_VS = 1'b0;
        repeat (2) @(posedge pixel_clk);
        #1 VGA_VS = 1'b1;
        repeat (pre_blank) @(posedge pixel_clk);
    endtask

    // Issue a VS falling edge and log read strobes over the following cycles.
    task automatic vs_and_log(input int ncyc);
        rd_addr_q.delete();
        rd_cyc_q.delete();
        @(posedge pixel_clk); #1 VGA_VS = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge pixel_clk);
            if (mem_en && !mem_we) begin
                rd_addr_q.push_back(int'(mem_addr));
                rd_cyc_q.push_back(k);
            end
            @(posedge pixel_clk); #1;
            if (k == 1) VGA_VS = 1'b1;
        end
        VGA_VS = 1'b1;
    endtask

    task automatic check_burst();
        chk("burst_read_count", 32'(rd_addr_q.size()), 16);
        for (int i = 0; i < rd_addr_q.size(); i++) begin
            chk("burst_read_addr", 32'(rd_addr_q[i]), 32'(i));
            chk("burst_read_consecutive", 32'(rd_cyc_q[i] - rd_cyc_q[0]), 32'(i));
        end
    endtask

    task automatic scan_lines();
        int idx = 0;
        for (int l = 0; l < V; l++) begin
            for (int p = 0; p < H; p++) begin
                @(posedge pixel_clk); #1 data_en = 1'b1;
                exp_q.push_back(model_ram[idx]);
                idx++;
            end
            @(posedge pixel_clk); #1 data_en = 1'b0;
            repeat ($urandom_range(2, 5)) @(posedge pixel_clk);
        end
        repeat (4) @(posedge pixel_clk);
        chk("scan_queue_drained", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int n;

        // Reset state.
        repeat (3) begin
            @(negedge pixel_clk);
            chk_all_zero("reset");
        end
        @(posedge pixel_clk); #1 rst = 1'b1;
        @(negedge pixel_clk);
        chk("wait_frame_wr_ready", 32'(wr_ready), 1);

        // Load the whole image through the host port while no frame runs.
        host_mode = 1;
        n = 0;
        while (load_ptr < 64 && n < 400) begin
            @(posedge pixel_clk);
            n++;
        end
        chk("image_load_done", 32'(load_ptr), 64);
        host_mode = 0;
        repeat (2) @(posedge pixel_clk);

        // Frame start with no host traffic: a 16-deep prefetch burst.
        vs_and_log(24);
        check_burst();
        mon_en = 1'b1;
        scan_lines();
        @(negedge pixel_clk);
        chk("done_wr_ready", 32'(wr_ready), 1);

        // Randomised frames: random image edits between frames, saturating
        // off-screen writes while scanout runs.
        for (int f = 0; f < 3; f++) begin
            host_mode = 3;
            repeat (30) @(posedge pixel_clk);
            host_mode = 2;
            repeat (3) @(posedge pixel_clk);
            vs_edge($urandom_range(8, 20));
            scan_lines();
        end

        // VS edge while a read is in flight restarts cleanly at address 0.
        host_mode = 0;
        repeat (3) @(posedge pixel_clk);
        vs_and_log(5);
        chk("inflight_reads_active", 32'(rd_addr_q.size() > 2), 1);
        vs_and_log(24);
        check_burst();
        scan_lines();

        // Starve the FIFO: data_en right after frame start.
        mon_en = 1'b0;
        repeat (2) @(posedge pixel_clk);
        @(posedge pixel_clk); #1 VGA_VS = 1'b0;
        @(posedge pixel_clk); #1 data_en = 1'b1;
        @(posedge pixel_clk); #1 data_en = 1'b0;
        VGA_VS = 1'b1;
        @(negedge pixel_clk);
        chk("starve_pix_black", 32'(pix_data), 0);
        chk("starve_underflow_set", 32'(underflow), 1);
        repeat (10) @(posedge pixel_clk);
        @(negedge pixel_clk);
        chk("underflow_sticky", 32'(underflow), 1);
        @(posedge pixel_clk); #1 VGA_VS = 1'b0;
        @(negedge pixel_clk);
        chk("underflow_held_until_edge", 32'(underflow), 1);
        @(negedge pixel_clk);
        chk("underflow_cleared_by_vs", 32'(underflow), 0);
        @(posedge pixel_clk); #1 VGA_VS = 1'b1;
        repeat (20) @(posedge pixel_clk);
        mon_en = 1'b1;
        scan_lines();

        // Asynchronous reset mid-line, then no fetch until a fresh VS edge.
        mon_en = 1'b0;
        host_mode = 2;
        repeat (3) @(posedge pixel_clk);
        vs_edge(20);
        host_mode = 0;
        repeat (2) @(posedge pixel_clk);
        repeat (3) begin
            @(posedge pixel_clk); #1 data_en = 1'b1;
        end
        @(posedge pixel_clk); #3 rst = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge pixel_clk); #1 rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge pixel_clk); #1 data_en = 1'($urandom_range(0, 1));
            @(negedge pixel_clk);
            chk("post_reset_no_mem", 32'(mem_en), 0);
            chk("post_reset_pix_black", 32'(pix_data), 0);
        end
        @(posedge pixel_clk); #1 data_en = 1'b0;
        repeat (2) @(posedge pixel_clk);
        mon_en = 1'b1;
        host_mode = 2;
        repeat (3) @(posedge pixel_clk);
        vs_edge(12);
        scan_lines();

        // Every accepted host write must have landed in the RAM.
        mon_en = 1'b0;
        host_mode = 0;
        repeat (4) @(posedge pixel_clk);
        for (int i = 0; i < 64; i++) begin
            chk("ram_contents", 32'(ram[i]), 32'(model_ram[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
